// File: rtl/input_conditioner.sv
// input_conditioner: synchronises and debounces the board's slide switches and
// push-buttons for the game logic, and produces one-cycle press strobes for the
// jump and start buttons.
// Optional build macro: INPUT_COND_DIR_LOCKOUT_EN. When defined, left_switch and
// right_switch are both forced to 0 while both debounced switches read 1.
// Channel order everywhere: [0] left, [1] right, [2] jump_n, [3] start_n.
module input_conditioner #(
    parameter int DEBOUNCE_CYCLES = 250000,
    parameter int SYNC_STAGES     = 2
) (
    input  logic vga_clock,
    input  logic reset,
    input  logic raw_left_sw,
    input  logic raw_right_sw,
    input  logic raw_jump_n,
    input  logic raw_start_n,
    output logic left_switch,
    output logic right_switch,
    output logic jump_button,
    output logic start_button,
    output logic jump_pulse,
    output logic start_pulse
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES);
    // The edge that leaves STABLE is itself the first stable cycle, so the count starts at 1.
    localparam logic [CW-1:0] CNT_FIRST = CW'(1);
    localparam logic [CW-1:0] CNT_LAST  = CW'(DEBOUNCE_CYCLES - 1);
    // Released level per channel: switches off (0), buttons not pressed (1).
    localparam logic [3:0] RELEASED = 4'b1100;

    typedef enum logic {
        ST_STABLE = 1'b0,
        ST_COUNT  = 1'b1
    } state_e;

    logic [3:0] raw_s;
    logic [3:0] lvl_d;

    assign raw_s = {raw_start_n, raw_jump_n, raw_right_sw, raw_left_sw};

    for (genvar g = 0; g < 4; g++) begin : g_chan
        logic [SYNC_STAGES-1:0] sync_q;
        logic                   s;
        state_e                 state_q;
        logic [CW-1:0]          cnt_q;
        logic                   lvl_q;
        logic                   accept;

        // Synchroniser chain; resets to the released level so reset never looks like a press.
        always_ff @(posedge vga_clock or posedge reset) begin
            if (reset) begin
                sync_q <= {SYNC_STAGES{RELEASED[g]}};
            end else begin
                sync_q <= {sync_q[SYNC_STAGES-2:0], raw_s[g]};
            end
        end

        assign s = sync_q[SYNC_STAGES-1];

        // Level accepted on this edge; the output stage uses it so that masking adds no latency.
        assign accept   = (state_q == ST_COUNT) && (s != lvl_q) && (cnt_q == CNT_LAST);
        assign lvl_d[g] = accept ? s : lvl_q;

        // Debounce FSM: accept a change only after DEBOUNCE_CYCLES consecutive differing samples.
        always_ff @(posedge vga_clock or posedge reset) begin
            if (reset) begin
                state_q <= ST_STABLE;
                cnt_q   <= '0;
                lvl_q   <= RELEASED[g];
            end else begin
                case (state_q)
                    ST_STABLE: begin
                        if (s != lvl_q) begin
                            state_q <= ST_COUNT;
                            cnt_q   <= CNT_FIRST;
                        end else begin
                            cnt_q   <= '0;
                        end
                    end
                    ST_COUNT: begin
                        if (s == lvl_q) begin
                            state_q <= ST_STABLE;
                            cnt_q   <= '0;
                        end else if (cnt_q == CNT_LAST) begin
                            lvl_q   <= s;
                            state_q <= ST_STABLE;
                            cnt_q   <= '0;
                        end else begin
                            cnt_q   <= cnt_q + CW'(1);
                        end
                    end
                    default: begin
                        state_q <= ST_STABLE;
                        cnt_q   <= '0;
                    end
                endcase
            end
        end
    end

    logic left_q;
    logic right_q;
    logic jump_q;
    logic start_q;
    logic jump_last_q;
    logic start_last_q;
    logic jump_pulse_q;
    logic start_pulse_q;

    // Output registers: clean levels, optional direction lockout, and press strobes one cycle after the fall.
    always_ff @(posedge vga_clock or posedge reset) begin
        if (reset) begin
            left_q        <= 1'b0;
            right_q       <= 1'b0;
            jump_q        <= 1'b1;
            start_q       <= 1'b1;
            jump_last_q   <= 1'b1;
            start_last_q  <= 1'b1;
            jump_pulse_q  <= 1'b0;
            start_pulse_q <= 1'b0;
        end else begin
`ifdef INPUT_COND_DIR_LOCKOUT_EN
            left_q        <= lvl_d[0] & ~lvl_d[1];
            right_q       <= lvl_d[1] & ~lvl_d[0];
`else
            left_q        <= lvl_d[0];
            right_q       <= lvl_d[1];
`endif
            jump_q        <= lvl_d[2];
            start_q       <= lvl_d[3];
            jump_last_q   <= jump_q;
            start_last_q  <= start_q;
            jump_pulse_q  <= jump_last_q & ~jump_q;
            start_pulse_q <= start_last_q & ~start_q;
        end
    end

    assign left_switch  = left_q;
    assign right_switch = right_q;
    assign jump_button  = jump_q;
    assign start_button = start_q;
    assign jump_pulse   = jump_pulse_q;
    assign start_pulse  = start_pulse_q;

endmodule

// File: tb/tb_input_conditioner.sv
// Directed, table-driven bench for input_conditioner with DEBOUNCE_CYCLES=4,
// SYNC_STAGES=2 (a clean change appears 6 edges after it is applied).
// Output vector order: {left, right, jump_button, start_button, jump_pulse, start_pulse}.
module tb_input_conditioner;

    logic vga_clock;
    logic reset;
    logic raw_left_sw;
    logic raw_right_sw;
    logic raw_jump_n;
    logic raw_start_n;
    logic left_switch;
    logic right_switch;
    logic jump_button;
    logic start_button;
    logic jump_pulse;
    logic start_pulse;

    logic [5:0] outs;
    assign outs = {left_switch, right_switch, jump_button, start_button, jump_pulse, start_pulse};

    int n_pass  = 0;
    int n_total = 0;

    typedef struct {
        logic [3:0] raw;   // {left, right, jump_n, start_n}
        logic [5:0] exp;
    } vec_t;

    vec_t tbl [26];

`ifdef INPUT_COND_DIR_LOCKOUT_EN
    localparam bit LOCKOUT = 1'b1;
`else
    localparam bit LOCKOUT = 1'b0;
`endif

    input_conditioner #(
        .DEBOUNCE_CYCLES(4),
        .SYNC_STAGES    (2)
    ) dut (
        .vga_clock   (vga_clock),
        .reset       (reset),
        .raw_left_sw (raw_left_sw),
        .raw_right_sw(raw_right_sw),
        .raw_jump_n  (raw_jump_n),
        .raw_start_n (raw_start_n),
        .left_switch (left_switch),
        .right_switch(right_switch),
        .jump_button (jump_button),
        .start_button(start_button),
        .jump_pulse  (jump_pulse),
        .start_pulse (start_pulse)
    );

    initial vga_clock = 1'b0;
    always #5 vga_clock = ~vga_clock;

    task automatic tick();
        @(posedge vga_clock);
        #1;
    endtask

    task automatic set_raw(input logic [3:0] r);
        {raw_left_sw, raw_right_sw, raw_jump_n, raw_start_n} = r;
    endtask

    task automatic check(input string name, input logic [5:0] act, input logic [5:0] exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    initial begin
        int pulses;
        logic [5:0] e_v;

        // Edge k row: raw applied before edge k+1, outputs checked just after it.
        tbl[0]  = '{4'b1010, 6'b001100};
        tbl[1]  = '{4'b1010, 6'b001100};
        tbl[2]  = '{4'b1010, 6'b001100};
        tbl[3]  = '{4'b1011, 6'b001100};
        tbl[4]  = '{4'b1011, 6'b001100};
        tbl[5]  = '{4'b1011, 6'b101100};
        tbl[6]  = '{4'b1011, 6'b101100};
        tbl[7]  = '{4'b1011, 6'b101100};
        tbl[8]  = '{4'b1010, 6'b101100};
        tbl[9]  = '{4'b1010, 6'b101100};
        tbl[10] = '{4'b1010, 6'b101100};
        tbl[11] = '{4'b1010, 6'b101100};
        tbl[12] = '{4'b1011, 6'b101100};
        tbl[13] = '{4'b1011, 6'b101000};
        tbl[14] = '{4'b1011, 6'b101001};
        tbl[15] = '{4'b1011, 6'b101000};
        tbl[16] = '{4'b1011, 6'b101000};
        tbl[17] = '{4'b1011, 6'b101100};
        tbl[18] = '{4'b1011, 6'b101100};
        tbl[19] = '{4'b0011, 6'b101100};
        tbl[20] = '{4'b0011, 6'b101100};
        tbl[21] = '{4'b0011, 6'b101100};
        tbl[22] = '{4'b0011, 6'b101100};
        tbl[23] = '{4'b0011, 6'b101100};
        tbl[24] = '{4'b0011, 6'b001100};
        tbl[25] = '{4'b0011, 6'b001100};

        // Reset held with jump pressed: reset values throughout.
        reset = 1'b1;
        set_raw(4'b0001);
        #1;
        check("reset_async", outs, 6'b001100);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("reset_hold", outs, 6'b001100);
        end
        reset = 1'b0;
        for (int e = 1; e <= 8; e++) begin
            tick();
            e_v = {2'b00, (e >= 6) ? 1'b0 : 1'b1, 1'b1, (e == 7) ? 1'b1 : 1'b0, 1'b0};
            check("held_through_reset", outs, e_v);
        end
        // Release jump: level returns after 6 edges, never a pulse.
        set_raw(4'b0011);
        for (int e = 1; e <= 8; e++) begin
            tick();
            e_v = {2'b00, (e >= 6) ? 1'b1 : 1'b0, 1'b1, 2'b00};
            check("jump_release", outs, e_v);
        end

        // Table: left latency, start filtering (3 low), start accept (4 low), left release.
        for (int i = 0; i < 26; i++) begin
            set_raw(tbl[i].raw);
            tick();
            check($sformatf("table_row%0d", i), outs, tbl[i].exp);
        end

        // Jump chatter: every-cycle toggling never gets through.
        for (int i = 0; i < 50; i++) begin
            raw_jump_n = (i % 2 == 0) ? 1'b0 : 1'b1;
            tick();
            check("chatter", {4'b0000, jump_button, jump_pulse}, 6'b000010);
        end
        raw_jump_n = 1'b0;
        pulses = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (jump_pulse === 1'b1) pulses++;
        end
        check("chatter_hold_pulses", 6'(pulses), 6'd1);
        check("chatter_hold_level", {5'b00000, jump_button}, 6'b000000);
        raw_jump_n = 1'b1;
        pulses = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (jump_pulse === 1'b1) pulses++;
        end
        check("release_no_pulse", 6'(pulses), 6'd0);
        check("release_level", {5'b00000, jump_button}, 6'b000001);

        // Both switches raised together.
        set_raw(4'b1111);
        for (int e = 1; e <= 8; e++) begin
            tick();
            e_v = {4'b0000, {2{(e >= 6) && !LOCKOUT}}};
            check("both_switches", {4'b0000, left_switch, right_switch}, e_v);
        end
        // Drop right.
        set_raw(4'b1011);
        for (int e = 1; e <= 8; e++) begin
            tick();
            if (LOCKOUT) begin
                e_v = {4'b0000, (e >= 6) ? 1'b1 : 1'b0, 1'b0};
            end else begin
                e_v = {4'b0000, 1'b1, (e < 6) ? 1'b1 : 1'b0};
            end
            check("drop_right", {4'b0000, left_switch, right_switch}, e_v);
        end

        // Reset in the middle of a start count, with left on.
        set_raw(4'b1010);
        for (int i = 0; i < 4; i++) begin
            tick();
        end
        check("pre_reset_state", outs, 6'b101100);
        #2;
        reset = 1'b1;
        #1;
        check("mid_count_reset_async", outs, 6'b001100);
        for (int i = 0; i < 2; i++) begin
            tick();
            check("mid_count_reset_hold", outs, 6'b001100);
        end
        reset = 1'b0;
        for (int e = 1; e <= 8; e++) begin
            tick();
            e_v = {(e >= 6) ? 1'b1 : 1'b0, 1'b0, 1'b1, (e >= 6) ? 1'b0 : 1'b1,
                   1'b0, (e == 7) ? 1'b1 : 1'b0};
            check("restart_after_reset", outs, e_v);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
